axis_div_core: RTL and testbench



---
 rtl/div_pkg.sv | 16 +
 rtl/axis_div_core_if.sv | 19 +
 rtl/div_restore_step.sv | 15 +
 rtl/axis_div_core.sv | 100 ++++++++++
 tb/tb_axis_div_core.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encodings, counter sizing and result-packing offsets for the divider
package div_pkg;
  typedef enum logic [3:0] {
    DIV_IDLE = 4'b0001,
    DIV_CALC = 4'b0010,
    DIV_FIX  = 4'b0100,
    DIV_DONE = 4'b1000
  } div_state_e;
  localparam int R_LSB = 0;
  function automatic int div_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
  function automatic int div_q_lsb(input int w);
    return w;
  endfunction
endpackage

// File: rtl/axis_div_core_if.sv
// axis_div_core_if: dividend/divisor slave channels and dout master channel of the divider
interface axis_div_core_if #(parameter int WIDTH = 32);
  logic               s_axis_dividend_tvalid;
  logic               s_axis_dividend_tready;
  logic [WIDTH-1:0]   s_axis_dividend_tdata;
  logic               s_axis_divisor_tvalid;
  logic               s_axis_divisor_tready;
  logic [WIDTH-1:0]   s_axis_divisor_tdata;
  logic               m_axis_dout_tvalid;
  logic [2*WIDTH-1:0] m_axis_dout_tdata;
  modport master (
    output s_axis_dividend_tvalid, s_axis_dividend_tdata, s_axis_divisor_tvalid, s_axis_divisor_tdata,
    input  s_axis_dividend_tready, s_axis_divisor_tready, m_axis_dout_tvalid, m_axis_dout_tdata
  );
  modport slave (
    input  s_axis_dividend_tvalid, s_axis_dividend_tdata, s_axis_divisor_tvalid, s_axis_divisor_tdata,
    output s_axis_dividend_tready, s_axis_divisor_tready, m_axis_dout_tvalid, m_axis_dout_tdata
  );
endinterface

// File: rtl/div_restore_step.sv
// div_restore_step: one restoring-division iteration (shift in next dividend bit, trial subtract)
module div_restore_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);
  logic [WIDTH+1:0] w_sh, w_sub;
  assign w_sh   = {i_rem, i_bit};
  assign w_sub  = w_sh - {2'b00, i_div};
  // no borrow out of the trial subtract means the divisor fits
  assign o_qbit = ~w_sub[WIDTH+1];
  assign o_rem  = o_qbit ? w_sub[WIDTH:0] : w_sh[WIDTH:0];
endmodule

// File: rtl/axis_div_core.sv
// axis_div_core: iterative radix-2 restoring divider; DIV_EARLY_OUT_EN skips CALC for zero divisor or |dividend| < |divisor|
module axis_div_core
  import div_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input logic            clk,
  input logic            resetn,
  axis_div_core_if.slave bus
);
  localparam int CW = div_cnt_w(WIDTH);
  localparam int QL = div_q_lsb(WIDTH);
  div_state_e         r_state, w_state_nxt;
  logic               r_tready, r_tvalid, w_tready_nxt, w_tvalid_nxt;
  logic [2*WIDTH-1:0] r_tdata;
  logic [WIDTH:0]     r_rem, w_rem_nxt;
  logic [WIDTH-1:0]   r_quo, r_div, w_a_abs, w_b_abs, w_q_fix, w_r_fix;
  logic [CW-1:0]      r_cnt;
  logic               r_qneg, r_rneg, r_dz;
  logic               w_acc, w_a_neg, w_b_neg, w_b_zero, w_early, w_qbit;
  assign w_acc    = bus.s_axis_dividend_tvalid && bus.s_axis_divisor_tvalid && r_tready;
  assign w_a_neg  = SIGNED && bus.s_axis_dividend_tdata[WIDTH-1];
  assign w_b_neg  = SIGNED && bus.s_axis_divisor_tdata[WIDTH-1];
  assign w_a_abs  = w_a_neg ? -bus.s_axis_dividend_tdata : bus.s_axis_dividend_tdata;
  assign w_b_abs  = w_b_neg ? -bus.s_axis_divisor_tdata : bus.s_axis_divisor_tdata;
  assign w_b_zero = bus.s_axis_divisor_tdata == '0;
`ifdef DIV_EARLY_OUT_EN
  assign w_early  = w_b_zero || (w_a_abs < w_b_abs);
`else
  assign w_early  = 1'b0;
`endif
  // the dividend shifts out of r_quo MSB-first while quotient bits shift in at the bottom
  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_bit (r_quo[WIDTH-1]),
    .i_div (r_div),
    .o_rem (w_rem_nxt),
    .o_qbit(w_qbit)
  );
  // zero divisor leaves the magnitude in r_rem, so only the quotient needs forcing
  assign w_q_fix = r_dz ? '1 : (r_qneg ? -r_quo : r_quo);
  assign w_r_fix = r_rneg ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
  // state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_state <= DIV_IDLE;
    else         r_state <= w_state_nxt;
  // next-state: IDLE -> CALC (or FIX on early out) -> FIX -> DONE -> IDLE
  always_comb begin
    w_state_nxt = (r_state == DIV_IDLE) ? (w_acc ? (w_early ? DIV_FIX : DIV_CALC) : DIV_IDLE) :
                  (r_state == DIV_CALC) ? ((r_cnt == '0) ? DIV_FIX : DIV_CALC) :
                  (r_state == DIV_FIX)  ? DIV_DONE : DIV_IDLE;
  end
  // outputs: tready only while idle and not accepting, tvalid pulses out of DONE
  always_comb begin
    w_tready_nxt = (r_state == DIV_IDLE) && !w_acc;
    w_tvalid_nxt = r_state == DIV_DONE;
  end
  // registered handshake and result outputs
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_tready <= 1'b0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
    end else begin
      r_tready <= w_tready_nxt;
      r_tvalid <= w_tvalid_nxt;
      if (r_state == DIV_FIX) begin
        r_tdata[QL +: WIDTH]    <= w_q_fix;
        r_tdata[R_LSB +: WIDTH] <= w_r_fix;
      end
    end
  // operand latch on accept, one restoring iteration per CALC cycle
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_dz   <= 1'b0;
    end else if (w_acc) begin
      r_rem  <= w_early ? {1'b0, w_a_abs} : '0;
      r_quo  <= w_early ? '0 : w_a_abs;
      r_div  <= w_b_abs;
      r_cnt  <= CW'(WIDTH - 1);
      r_qneg <= w_a_neg ^ w_b_neg;
      r_rneg <= w_a_neg;
      r_dz   <= w_b_zero;
    end else if (r_state == DIV_CALC) begin
      r_rem  <= w_rem_nxt;
      r_quo  <= {r_quo[WIDTH-2:0], w_qbit};
      r_cnt  <= r_cnt - 1'b1;
    end
  assign bus.s_axis_dividend_tready = r_tready;
  assign bus.s_axis_divisor_tready  = r_tready;
  assign bus.m_axis_dout_tvalid     = r_tvalid;
  assign bus.m_axis_dout_tdata      = r_tdata;
endmodule

// File: tb/tb_axis_div_core.sv
// tb_axis_div_core: scoreboard bench for signed and unsigned axis_div_core instances
module tb_axis_div_core;
  typedef struct {logic [63:0] d; longint e;} exp_t;
  localparam int LN = 34;
`ifdef DIV_EARLY_OUT_EN
  localparam int LE = 2;
`else
  localparam int LE = 34;
`endif
  logic   clk = 1'b0;
  logic   resetn = 1'b1;
  longint cyc = 0;
  int     n_vec = 0, n_bad = 0;
  exp_t   qs[$], qu[$];
  axis_div_core_if #(.WIDTH(32)) bs();
  axis_div_core_if #(.WIDTH(32)) bu();
  axis_div_core #(.WIDTH(32), .SIGNED(1'b1)) u_s (.clk(clk), .resetn(resetn), .bus(bs.slave));
  axis_div_core #(.WIDTH(32), .SIGNED(1'b0)) u_u (.clk(clk), .resetn(resetn), .bus(bu.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic monitor();
    exp_t x;
    forever begin
      @(negedge clk);
      if (bs.m_axis_dout_tvalid) begin
        if (qs.size() == 0) chk("s_spurious_tvalid", 64'd1, 64'd0);
        else begin
          x = qs.pop_front();
          chk("s_result", bs.m_axis_dout_tdata, x.d);
          chk("s_result_edge", 64'(cyc), 64'(x.e));
        end
      end
      if (bu.m_axis_dout_tvalid) begin
        if (qu.size() == 0) chk("u_spurious_tvalid", 64'd1, 64'd0);
        else begin
          x = qu.pop_front();
          chk("u_result", bu.m_axis_dout_tdata, x.d);
          chk("u_result_edge", 64'(cyc), 64'(x.e));
        end
      end
    end
  endtask
  task automatic div_op(input bit sg, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                        input int lat, input bit push, input bit hold, output longint acc);
    int w;
    logic rdy;
    @(negedge clk);
    if (sg) begin
      bs.s_axis_dividend_tdata = a; bs.s_axis_divisor_tdata = b;
      bs.s_axis_dividend_tvalid = 1'b1; bs.s_axis_divisor_tvalid = 1'b1;
    end else begin
      bu.s_axis_dividend_tdata = a; bu.s_axis_divisor_tdata = b;
      bu.s_axis_dividend_tvalid = 1'b1; bu.s_axis_divisor_tvalid = 1'b1;
    end
    w = 0;
    rdy = sg ? bs.s_axis_dividend_tready : bu.s_axis_dividend_tready;
    while (!rdy && w < 100) begin
      @(negedge clk);
      w++;
      rdy = sg ? bs.s_axis_dividend_tready : bu.s_axis_dividend_tready;
    end
    acc = cyc + 1;
    if (!rdy) chk("accept_timeout", 64'd0, 64'd1);
    else if (push) begin
      if (sg) qs.push_back('{exp, acc + lat});
      else    qu.push_back('{exp, acc + lat});
    end
    @(posedge clk);
    if (!hold) begin
      @(negedge clk);
      bs.s_axis_dividend_tvalid = 1'b0; bs.s_axis_divisor_tvalid = 1'b0;
      bu.s_axis_dividend_tvalid = 1'b0; bu.s_axis_divisor_tvalid = 1'b0;
    end
  endtask
  initial begin
    longint a1, a2;
    int w;
    bs.s_axis_dividend_tvalid = 1'b0; bs.s_axis_divisor_tvalid = 1'b0;
    bu.s_axis_dividend_tvalid = 1'b0; bu.s_axis_divisor_tvalid = 1'b0;
    bs.s_axis_dividend_tdata = '0; bs.s_axis_divisor_tdata = '0;
    bu.s_axis_dividend_tdata = '0; bu.s_axis_divisor_tdata = '0;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_tready", 64'(bs.s_axis_dividend_tready), 64'd0);
    chk("rst_u_tready", 64'(bu.s_axis_divisor_tready), 64'd0);
    chk("rst_s_tvalid", 64'(bs.m_axis_dout_tvalid), 64'd0);
    chk("rst_s_tdata", bs.m_axis_dout_tdata, 64'd0);
    resetn = 1'b1;
    #1 chk("rel_tready_low", 64'(bs.s_axis_dividend_tready), 64'd0);
    @(negedge clk);
    chk("rel_s_tready_high", 64'(bs.s_axis_divisor_tready), 64'd1);
    chk("rel_u_tready_high", 64'(bu.s_axis_dividend_tready), 64'd1);
    fork monitor(); join_none
    div_op(1, 32'd7, 32'd2, {32'h3, 32'h1}, LN, 1, 0, a1);
    div_op(1, -32'sd7, 32'd2, {32'hFFFFFFFD, 32'hFFFFFFFF}, LN, 1, 0, a1);
    div_op(1, 32'h80000000, 32'hFFFFFFFF, {32'h80000000, 32'h0}, LN, 1, 0, a1);
    div_op(1, 32'd7, -32'sd2, {32'hFFFFFFFD, 32'h1}, LN, 1, 0, a1);
    div_op(1, -32'sd7, -32'sd2, {32'h3, 32'hFFFFFFFF}, LN, 1, 0, a1);
    div_op(1, 32'd7, 32'd0, {32'hFFFFFFFF, 32'h7}, LE, 1, 0, a1);
    div_op(1, -32'sd5, 32'd0, {32'hFFFFFFFF, 32'hFFFFFFFB}, LE, 1, 0, a1);
    div_op(0, 32'hFFFFFFFF, 32'h10, {32'h0FFFFFFF, 32'hF}, LN, 1, 0, a1);
    div_op(0, 32'h1234, 32'h0, {32'hFFFFFFFF, 32'h1234}, LE, 1, 0, a1);
    div_op(0, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, LE, 1, 0, a1);
    @(negedge clk);
    bs.s_axis_dividend_tdata = 32'd20;
    bs.s_axis_dividend_tvalid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("lone_tvalid_tready", 64'(bs.s_axis_dividend_tready), 64'd1);
    end
    div_op(1, 32'd20, 32'd4, {32'h5, 32'h0}, LN, 1, 0, a1);
    w = 0;
    while (qs.size() != 0 && w < 100) begin @(negedge clk); w++; end
    div_op(1, 32'd1000, 32'd3, 64'd0, LN, 0, 0, a1);
    while (cyc < a1 + 15) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("abort_tvalid", 64'(bs.m_axis_dout_tvalid), 64'd0);
    chk("abort_tdata", bs.m_axis_dout_tdata, 64'd0);
    chk("abort_tready", 64'(bs.s_axis_dividend_tready), 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1 chk("abort_rel_tready_low", 64'(bs.s_axis_dividend_tready), 64'd0);
    @(negedge clk);
    chk("abort_rel_tready_high", 64'(bs.s_axis_dividend_tready), 64'd1);
    div_op(1, 32'd9, 32'd3, {32'h3, 32'h0}, LN, 1, 0, a1);
    div_op(1, 32'd100, 32'd7, {32'd14, 32'd2}, LN, 1, 1, a1);
    div_op(1, 32'd50, 32'd5, {32'd10, 32'd0}, LN, 1, 0, a2);
    chk("b2b_accept_gap", 64'(a2 - a1), 64'd36);
`ifdef DIV_EARLY_OUT_EN
    div_op(1, 32'd3, 32'd5, {32'h0, 32'h3}, LE, 1, 0, a1);
    div_op(1, -32'sd3, 32'd5, {32'h0, 32'hFFFFFFFD}, LE, 1, 0, a1);
`endif
    w = 0;
    while ((qs.size() != 0 || qu.size() != 0) && w < 100) begin @(negedge clk); w++; end
    @(negedge clk);
    chk("drain_pending", 64'(qs.size() + qu.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
